// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
//   Consumer end of the decode-stage control bundles (WB/M/EX) for a 5-stage
//   MIPS core. Carries the bundles through ID/EX, EX/MEM and MEM/WB, hands
//   each stage its control signals, inserts load-use stall bubbles and
//   resolves BEQ/BNE in MEM (flushing the younger stages).
//
// Ports
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_id_wb   {RegWrite, MemToReg}  i_id_m  {BNE, BEQ, MemRead, MemWrite}
//   i_id_ex   {RegDst, ALUsrc, ALUop}
//   i_id_valid                      decode holds a real instruction
//   i_id_rs/rt/rd                   register fields of the decoding instruction
//   i_mem_zero                      ALU zero flag of the MEM-stage instruction
//   o_ex_*                          EX-stage controls
//   o_mem_*                         MEM-stage controls, o_mem_br_taken = PC source
//   o_wb_*                          write-back controls and write address
//   o_stall                         hold PC and IF/ID
//   o_flush_ifid                    squash IF/ID
module ctrl_pipeline #(
    parameter int ALUOP_W     = 5,
    parameter int REG_AW      = 5,
    parameter bit LOAD_USE_EN = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_id_wb,
    input  logic [3:0]           i_id_m,
    input  logic [ALUOP_W+1:0]   i_id_ex,
    input  logic                 i_id_valid,
    input  logic [REG_AW-1:0]    i_id_rs,
    input  logic [REG_AW-1:0]    i_id_rt,
    input  logic [REG_AW-1:0]    i_id_rd,
    input  logic                 i_mem_zero,
    output logic [ALUOP_W-1:0]   o_ex_alu_op,
    output logic                 o_ex_alu_src,
    output logic                 o_ex_reg_dst,
    output logic                 o_mem_mem_read,
    output logic                 o_mem_mem_write,
    output logic                 o_mem_br_taken,
    output logic                 o_wb_reg_write,
    output logic                 o_wb_mem_to_reg,
    output logic [REG_AW-1:0]    o_wb_dest,
    output logic                 o_stall,
    output logic                 o_flush_ifid
);

    // M bundle bit positions
    localparam int M_WR  = 0;
    localparam int M_RD  = 1;
    localparam int M_BEQ = 2;
    localparam int M_BNE = 3;

    // ID/EX
    logic [1:0]         r_idex_wb;
    logic [3:0]         r_idex_m;
    logic [ALUOP_W+1:0] r_idex_ex;
    logic [REG_AW-1:0]  r_idex_rt;
    logic [REG_AW-1:0]  r_idex_rd;
    // EX/MEM
    logic [1:0]         r_exmem_wb;
    logic [3:0]         r_exmem_m;
    logic [REG_AW-1:0]  r_exmem_dest;
    // MEM/WB
    logic [1:0]         r_memwb_wb;
    logic [REG_AW-1:0]  r_memwb_dest;

    logic               w_load_use;
    logic               w_br_taken;
    logic               w_idex_bubble;
    logic [REG_AW-1:0]  w_ex_dest;

    assign w_br_taken = (r_exmem_m[M_BEQ] &  i_mem_zero) |
                        (r_exmem_m[M_BNE] & ~i_mem_zero);

    // Rt of a load in EX is consumed by the decoding instruction; $zero never hazards.
    assign w_load_use = LOAD_USE_EN && i_id_valid && r_idex_m[M_RD] &&
                        (r_idex_rt != '0) &&
                        ((r_idex_rt == i_id_rs) || (r_idex_rt == i_id_rt));

    // A taken branch already squashes the decoding instruction, so a
    // simultaneous stall would only hold a dead instruction.
    assign w_idex_bubble = !i_id_valid || w_load_use || w_br_taken;

    assign w_ex_dest = r_idex_ex[ALUOP_W+1] ? r_idex_rd : r_idex_rt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idex_wb    <= '0;
            r_idex_m     <= '0;
            r_idex_ex    <= '0;
            r_idex_rt    <= '0;
            r_idex_rd    <= '0;
            r_exmem_wb   <= '0;
            r_exmem_m    <= '0;
            r_exmem_dest <= '0;
            r_memwb_wb   <= '0;
            r_memwb_dest <= '0;
        end else begin
            if (w_idex_bubble) begin
                r_idex_wb <= '0;
                r_idex_m  <= '0;
                r_idex_ex <= '0;
                r_idex_rt <= '0;
                r_idex_rd <= '0;
            end else begin
                r_idex_wb <= i_id_wb;
                r_idex_m  <= i_id_m;
                r_idex_ex <= i_id_ex;
                r_idex_rt <= i_id_rt;
                r_idex_rd <= i_id_rd;
            end

            if (w_br_taken) begin
                r_exmem_wb   <= '0;
                r_exmem_m    <= '0;
                r_exmem_dest <= '0;
            end else begin
                r_exmem_wb   <= r_idex_wb;
                r_exmem_m    <= r_idex_m;
                r_exmem_dest <= w_ex_dest;
            end

            // The branch itself still retires (its bundle never writes).
            r_memwb_wb   <= r_exmem_wb;
            r_memwb_dest <= r_exmem_dest;
        end
    end

    assign o_ex_alu_op     = r_idex_ex[ALUOP_W-1:0];
    assign o_ex_alu_src    = r_idex_ex[ALUOP_W];
    assign o_ex_reg_dst    = r_idex_ex[ALUOP_W+1];
    assign o_mem_mem_read  = r_exmem_m[M_RD];
    assign o_mem_mem_write = r_exmem_m[M_WR];
    assign o_mem_br_taken  = w_br_taken;
    assign o_wb_reg_write  = r_memwb_wb[1] && (r_memwb_dest != '0);
    assign o_wb_mem_to_reg = r_memwb_wb[0];
    assign o_wb_dest       = r_memwb_dest;
    assign o_stall         = w_load_use && !w_br_taken;
    assign o_flush_ifid    = w_br_taken;

endmodule
